weight_buffer_ctrl: RTL and testbench
=====================================

WEIGHT_BUFFER_CTRL -- requirements
Module: weight_buffer_ctrl

Interface
REQ-001 Parameter RD_WIDTH, default 16, read word width of the controlled weight buffer.
REQ-002 Parameter WR_WIDTH, default 64, write word width; WR_WIDTH/RD_WIDTH is a power of two.
REQ-003 Parameter RD_ADDR_WIDTH, default 7, buffer read address width.
REQ-004 Parameter WR_ADDR_WIDTH, default 5, buffer write address width.
REQ-005 Parameter REPEAT_WIDTH, default 8, width of the pass-repeat count.
REQ-006 Ports, in order:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle start pulse.
- cfg_num_words  in  WR_ADDR_WIDTH+1  write words to load.
- cfg_num_reads  in  RD_ADDR_WIDTH+1  read words per pass.
- cfg_repeat  in  REPEAT_WIDTH  number of read passes.
- wr_valid  in  1  load stream valid.
- wr_data  in  WR_WIDTH  load stream data.
- wr_ready  out  1  load stream ready.
- pe_stall  in  1  consumer back-pressure.
- buf_write_req  out  1  buffer write strobe.
- buf_write_addr  out  WR_ADDR_WIDTH  buffer write address.
- buf_write_data  out  WR_WIDTH  buffer write data.
- buf_read_req  out  1  buffer read strobe.
- buf_read_addr  out  RD_ADDR_WIDTH  buffer read address.
- rd_data_valid  out  1  buffer read_data valid this cycle.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-007 FSM states: IDLE, LOAD, READ, DRAIN, DONE.
REQ-008 Start transitions:
- IDLE + cfg_start: latch all cfg_* inputs.
- Next state is LOAD if cfg_num_words != 0.
- Otherwise READ if cfg_num_reads != 0 and cfg_repeat != 0.
- Otherwise DONE.
REQ-009 cfg_start outside IDLE is ignored.
REQ-010 wr_ready is 1 only in LOAD.
REQ-011 Each wr_valid&&wr_ready cycle:
- Drive buf_write_req=1 combinationally, with buf_write_data=wr_data and buf_write_addr=write counter.
- Increment the write counter.
REQ-012 The write counter starts at 0 per job and wraps modulo 2^WR_ADDR_WIDTH.
REQ-013 After the cfg_num_words-th accepted beat, LOAD goes to READ if cfg_num_reads and cfg_repeat are nonzero, else to DRAIN.
REQ-014 In READ, buf_read_req=1 whenever pe_stall=0.
- buf_read_addr equals the read counter, starting at 0.
- The read counter increments on each request.
REQ-015 When the read counter reaches cfg_num_reads-1 and is issued:
- The counter returns to 0 and the pass counter increments.
- After cfg_repeat passes, the FSM goes to DRAIN.
REQ-016 pe_stall=1 holds the read and pass counters and issues no request; there are no bubbles after stall release.
REQ-017 rd_data_valid is buf_read_req delayed by exactly 3 cycles through a 3-stage shift register, matching buffer read latency.
REQ-018 DRAIN waits until the shift register is empty, then goes to DONE.
REQ-019 DONE asserts done for one cycle, then goes to IDLE.
REQ-020 busy=1 in LOAD, READ, DRAIN and DONE.
REQ-021 buf_write_req and buf_read_req are never asserted in the same cycle.
REQ-022 Total read requests per job equal cfg_num_reads*cfg_repeat.

Reset
REQ-023 Reset asserted at any time, including mid-job:
- FSM goes to IDLE.
- All counters and the valid shift register clear to 0.
- All outputs go to 0: wr_ready, buf_*_req, buf_*_addr, buf_write_data, rd_data_valid, busy, done.
- In-flight valids are discarded.
REQ-024 The first cfg_start is accepted the first cycle after reset deasserts.

Structure
REQ-025 FSM state encodings and the 3-cycle buffer read latency constant belong in the shared dnnweaver package/header used alongside common.vh.
REQ-026 The latency-matching valid shift register is a single sub-module, delay_line, parameterized by depth and width.
REQ-027 The controller sits beside, and does not instantiate, weight_buffer.

Verification
REQ-028 Load and read: words=4, reads=16, repeat=1, no stall.
- 4 writes at addresses 0..3.
- 16 reads at addresses 0..15.
- rd_data_valid high for 16 cycles starting 3 cycles after the first read.
- Single done pulse.
REQ-029 Repeat: words=2, reads=8, repeat=3.
- Read address sequence 0..7 three times, 24 requests total.
REQ-030 Stall: pe_stall pulsed for 2 cycles after read address 5, with reads=10.
- Address 6 issued immediately after release.
- No repeated or skipped addresses.
REQ-031 Zero counts: words=0, reads=0.
- IDLE→DONE→IDLE, done one cycle after start, no buffer strobes.
REQ-032 Write gaps and wrap: wr_valid gapped, words=32.
- Writes at addresses 0..31 only on handshake cycles.
- Write counter back to 0 afterwards.
REQ-033 Mid-READ reset: assert reset during READ.
- All outputs 0 immediately.
- Following cfg_start runs a full job correctly.

Source files
------------

// File: rtl/weight_buffer_ctrl_pkg.sv
// Shared definitions for the weight buffer controller: FSM states and the
// read latency of the weight buffer that the valid pipeline must match.
package weight_buffer_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned BUF_RD_LATENCY = 3;

endpackage

// File: rtl/weight_buffer_ctrl_delay_line.sv
// Fixed-depth shift register; pending_o is high while any stage holds a
// nonzero value so the owner can tell when the line has drained.
module delay_line #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             pending_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

  always_comb begin
    pending_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) pending_o = pending_o | (|stage_q[i]);
  end

endmodule

// File: rtl/weight_buffer_ctrl.sv
// Weight buffer controller: loads a job's write words, then replays the read
// window cfg_repeat times with back-pressure and latency-matched read valids.
module weight_buffer_ctrl
  import weight_buffer_ctrl_pkg::*;
#(
  parameter int unsigned RD_WIDTH      = 16,
  parameter int unsigned WR_WIDTH      = 64,
  parameter int unsigned RD_ADDR_WIDTH = 7,
  parameter int unsigned WR_ADDR_WIDTH = 5,
  parameter int unsigned REPEAT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_start,
  input  logic [WR_ADDR_WIDTH:0]   cfg_num_words,
  input  logic [RD_ADDR_WIDTH:0]   cfg_num_reads,
  input  logic [REPEAT_WIDTH-1:0]  cfg_repeat,
  input  logic                     wr_valid,
  input  logic [WR_WIDTH-1:0]      wr_data,
  output logic                     wr_ready,
  input  logic                     pe_stall,
  output logic                     buf_write_req,
  output logic [WR_ADDR_WIDTH-1:0] buf_write_addr,
  output logic [WR_WIDTH-1:0]      buf_write_data,
  output logic                     buf_read_req,
  output logic [RD_ADDR_WIDTH-1:0] buf_read_addr,
  output logic                     rd_data_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned RATIO = WR_WIDTH / RD_WIDTH;

  if ((WR_WIDTH % RD_WIDTH) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("WR_WIDTH/RD_WIDTH must be a power of two");
  end

  state_e state_q, state_d;

  logic [WR_ADDR_WIDTH:0]   num_words_q;
  logic [RD_ADDR_WIDTH:0]   num_reads_q;
  logic [REPEAT_WIDTH-1:0]  repeat_q;
  // One extra bit so a full 2^WR_ADDR_WIDTH load can be counted; the address
  // uses the low bits, which gives the required modulo wrap.
  logic [WR_ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
  logic [RD_ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [REPEAT_WIDTH-1:0]  pass_q, pass_d;

  logic last_beat, last_read, last_pass, reads_needed, pipe_pending;

  assign last_beat    = (wr_cnt_q == num_words_q - (WR_ADDR_WIDTH+1)'(1));
  assign last_read    = ({1'b0, rd_cnt_q} == num_reads_q - (RD_ADDR_WIDTH+1)'(1));
  assign last_pass    = (pass_q == repeat_q - REPEAT_WIDTH'(1));
  assign reads_needed = (num_reads_q != '0) && (repeat_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      num_words_q <= '0;
      num_reads_q <= '0;
      repeat_q    <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      pass_q      <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      pass_q   <= pass_d;
      if (state_q == IDLE && cfg_start) begin
        num_words_q <= cfg_num_words;
        num_reads_q <= cfg_num_reads;
        repeat_q    <= cfg_repeat;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    pass_d         = pass_q;
    wr_ready       = 1'b0;
    buf_write_req  = 1'b0;
    buf_write_addr = '0;
    buf_write_data = '0;
    buf_read_req   = 1'b0;
    buf_read_addr  = '0;
    busy           = (state_q != IDLE);
    done           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          pass_d   = '0;
          if (cfg_num_words != '0)                         state_d = LOAD;
          else if (cfg_num_reads != '0 && cfg_repeat != '0) state_d = READ;
          else                                              state_d = DONE;
        end
      end
      LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          buf_write_req  = 1'b1;
          buf_write_addr = wr_cnt_q[WR_ADDR_WIDTH-1:0];
          buf_write_data = wr_data;
          if (last_beat) begin
            wr_cnt_d = '0;
            state_d  = reads_needed ? READ : DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + (WR_ADDR_WIDTH+1)'(1);
          end
        end
      end
      READ: begin
        if (!pe_stall) begin
          buf_read_req  = 1'b1;
          buf_read_addr = rd_cnt_q;
          if (last_read) begin
            rd_cnt_d = '0;
            if (last_pass) begin
              pass_d  = '0;
              state_d = DRAIN;
            end else begin
              pass_d = pass_q + REPEAT_WIDTH'(1);
            end
          end else begin
            rd_cnt_d = rd_cnt_q + RD_ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (!pipe_pending) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  delay_line #(
    .DEPTH(BUF_RD_LATENCY),
    .WIDTH(1)
  ) u_valid_pipe (
    .clk_i    (clk),
    .rst_i    (reset),
    .din_i    (buf_read_req),
    .dout_o   (rd_data_valid),
    .pending_o(pipe_pending)
  );

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Scoreboard bench for weight_buffer_ctrl: jobs push expected writes, read
// addresses and done pulses; a negedge monitor pops and compares.
module tb_weight_buffer_ctrl;

  localparam int unsigned RDW = 16;
  localparam int unsigned WRW = 64;
  localparam int unsigned RAW = 7;
  localparam int unsigned WAW = 5;
  localparam int unsigned RPW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_start;
  logic [WAW:0]   cfg_num_words;
  logic [RAW:0]   cfg_num_reads;
  logic [RPW-1:0] cfg_repeat;
  logic           wr_valid;
  logic [WRW-1:0] wr_data;
  logic           wr_ready;
  logic           pe_stall;
  logic           buf_write_req;
  logic [WAW-1:0] buf_write_addr;
  logic [WRW-1:0] buf_write_data;
  logic           buf_read_req;
  logic [RAW-1:0] buf_read_addr;
  logic           rd_data_valid;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  weight_buffer_ctrl #(
    .RD_WIDTH(RDW), .WR_WIDTH(WRW), .RD_ADDR_WIDTH(RAW),
    .WR_ADDR_WIDTH(WAW), .REPEAT_WIDTH(RPW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start),
    .cfg_num_words(cfg_num_words), .cfg_num_reads(cfg_num_reads), .cfg_repeat(cfg_repeat),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .pe_stall(pe_stall),
    .buf_write_req(buf_write_req), .buf_write_addr(buf_write_addr), .buf_write_data(buf_write_data),
    .buf_read_req(buf_read_req), .buf_read_addr(buf_read_addr),
    .rd_data_valid(rd_data_valid), .busy(busy), .done(done)
  );

  typedef struct {
    logic [WAW-1:0] addr;
    logic [WRW-1:0] data;
  } wr_t;

  wr_t               exp_wr[$];
  int unsigned       exp_rd[$];
  longint unsigned   vq[$];
  int                exp_done;
  int                checks;
  int                errors;
  longint unsigned   cyc;
  int                rd_seen;
  int                stall_mode;
  bit                addr5_flag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_ready"}, 64'(wr_ready), 64'(0));
    chk({tag, "_wr_req"}, 64'(buf_write_req), 64'(0));
    chk({tag, "_wr_addr"}, 64'(buf_write_addr), 64'(0));
    chk({tag, "_wr_data"}, 64'(buf_write_data), 64'(0));
    chk({tag, "_rd_req"}, 64'(buf_read_req), 64'(0));
    chk({tag, "_rd_addr"}, 64'(buf_read_addr), 64'(0));
    chk({tag, "_rd_valid"}, 64'(rd_data_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  // Monitor: every request popped against the reference queues; each read
  // request predicts a valid exactly three cycles later.
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        chk("wr_rd_exclusive", 64'(buf_write_req & buf_read_req), 64'(0));
        if (rd_data_valid) begin
          if (vq.size() == 0) chk("rd_valid_unexpected", 64'(rd_data_valid), 64'(0));
          else                chk("rd_valid_cycle", cyc, vq.pop_front());
        end
        if (buf_write_req) begin
          if (exp_wr.size() == 0) chk("wr_req_unexpected", 64'(buf_write_req), 64'(0));
          else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", 64'(buf_write_addr), 64'(e.addr));
            chk("wr_data", buf_write_data, e.data);
          end
        end
        if (pe_stall) chk("req_while_stall", 64'(buf_read_req), 64'(0));
        if (buf_read_req) begin
          rd_seen++;
          if (stall_mode == 2 && buf_read_addr == 5 && !pe_stall) addr5_flag = 1'b1;
          if (exp_rd.size() == 0) chk("rd_req_unexpected", 64'(buf_read_req), 64'(0));
          else                    chk("rd_addr", 64'(buf_read_addr), 64'(exp_rd.pop_front()));
          vq.push_back(cyc + 3);
        end else if (busy && !wr_ready && exp_rd.size() > 0 && !pe_stall) begin
          chk("rd_no_bubble", 64'(buf_read_req), 64'(1));
        end
        if (done) begin
          chk("done_expected", 64'(exp_done > 0), 64'(1));
          if (exp_done > 0) exp_done--;
        end
      end
    end
  end

  // Back-pressure source: off, random, or one 2-cycle pulse after address 5.
  initial begin
    int hold;
    hold = 0;
    pe_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        pe_stall = 1'b1;
        hold--;
      end else if (stall_mode == 2 && addr5_flag) begin
        pe_stall   = 1'b1;
        hold       = 1;
        addr5_flag = 1'b0;
        stall_mode = 0;
      end else if (stall_mode == 1) begin
        pe_stall = ($urandom_range(0, 3) == 0);
      end else begin
        pe_stall = 1'b0;
      end
    end
  end

  // Called at posedge+1; the start pulse is sampled at the next edge.
  task automatic run_job(input int w, input int r, input int rep, input int smode,
                         input bit gap, input bit spurious, input int abort_n, input bit zero_chk);
    logic [WRW-1:0] data[$];
    wr_t e;
    int  k;
    bit  got_done, hs, seen_busy;
    for (int i = 0; i < w; i++) begin
      data.push_back({$urandom, $urandom});
      e.addr = WAW'(i % 32);
      e.data = data[i];
      exp_wr.push_back(e);
    end
    for (int p = 0; p < rep; p++)
      for (int a = 0; a < r; a++) exp_rd.push_back(a);
    exp_done++;
    rd_seen    = 0;
    addr5_flag = 1'b0;
    stall_mode = smode;
    cfg_start     = 1'b1;
    cfg_num_words = (WAW+1)'(w);
    cfg_num_reads = (RAW+1)'(r);
    cfg_repeat    = RPW'(rep);
    k        = 0;
    wr_valid = (w > 0);
    wr_data  = (w > 0) ? data[0] : '0;
    got_done = 1'b0;
    for (int c = 0; c < 4000 && !got_done; c++) begin
      @(negedge clk);
      hs        = wr_valid && wr_ready;
      seen_busy = busy;
      if (done) begin
        got_done  = 1'b1;
        cfg_start = 1'b0;
        wr_valid  = 1'b0;
        if (zero_chk) chk("zero_done_latency", 64'(c), 64'(1));
      end else begin
        @(posedge clk);
        #1;
        cfg_start     = spurious && seen_busy && ($urandom_range(0, 4) == 0);
        cfg_num_words = (WAW+1)'($urandom);
        cfg_num_reads = (RAW+1)'($urandom);
        cfg_repeat    = RPW'($urandom);
        if (hs) k++;
        if (k < w) begin
          wr_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
          wr_data  = data[k];
        end else begin
          wr_valid = ($urandom_range(0, 1) == 1);
          wr_data  = {$urandom, $urandom};
        end
        if (abort_n > 0 && rd_seen >= abort_n) begin
          reset = 1'b1;
          #1;
          chk_all_zero("midrst");
          exp_wr.delete();
          exp_rd.delete();
          vq.delete();
          exp_done   = 0;
          cfg_start  = 1'b0;
          wr_valid   = 1'b0;
          stall_mode = 0;
          @(posedge clk);
          #1;
          reset = 1'b0;
          return;
        end
      end
    end
    chk("done_seen", 64'(got_done), 64'(1));
    cfg_start = 1'b0;
    @(posedge clk);
    #1;
    chk("job_wr_left", 64'(exp_wr.size()), 64'(0));
    chk("job_rd_left", 64'(exp_rd.size()), 64'(0));
    chk("job_valid_left", 64'(vq.size()), 64'(0));
    chk("job_done_left", 64'(exp_done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("done_one_cycle", 64'(done), 64'(0));
    exp_wr.delete();
    exp_rd.delete();
    vq.delete();
    exp_done   = 0;
    stall_mode = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_done = 0;
    stall_mode = 0;
    addr5_flag = 1'b0;
    rd_seen = 0;
    reset = 1'b1;
    cfg_start = 1'b0;
    cfg_num_words = '0;
    cfg_num_reads = '0;
    cfg_repeat = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    run_job(4, 16, 1, 0, 1'b0, 1'b0, 0, 1'b0);
    run_job(2, 8, 3, 0, 1'b0, 1'b1, 0, 1'b0);
    run_job(3, 10, 1, 2, 1'b0, 1'b0, 0, 1'b0);
    run_job(0, 0, 1, 0, 1'b0, 1'b0, 0, 1'b1);
    run_job(32, 4, 1, 0, 1'b1, 1'b0, 0, 1'b0);
    run_job(3, 2, 1, 0, 1'b0, 1'b0, 0, 1'b0);
    run_job(1, 0, 2, 0, 1'b0, 1'b0, 0, 1'b0);
    run_job(0, 5, 2, 1, 1'b0, 1'b0, 0, 1'b0);
    run_job(5, 8, 2, 1, 1'b1, 1'b0, 5, 1'b0);
    run_job(4, 16, 1, 0, 1'b0, 1'b0, 0, 1'b0);
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(0, 32), $urandom_range(0, 20), $urandom_range(0, 3),
              1, 1'b1, 1'b1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
